iterative_alu: RTL

//  Execute-stage ALU consuming the 4-bit aluselect code from the ALU controller.

---
 rtl/iterative_alu.sv | 125 ++++++++++++
 1 files changed

// File: rtl/iterative_alu.sv
// Execute-stage ALU: single-cycle logic/arith ops, iterative shifts of SHIFT_STEP bits per cycle,
// valid/ready handshake on both the operand and the result side.
module iterative_alu #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned SHIFT_STEP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       aluselect,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             illegal
);

  localparam int unsigned SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_SLL   = 4'd2;
  localparam logic [3:0] OP_SRL   = 4'd3;
  localparam logic [3:0] OP_SRA   = 4'd4;
  localparam logic [3:0] OP_AND   = 4'd5;
  localparam logic [3:0] OP_OR    = 4'd6;
  localparam logic [3:0] OP_XOR   = 4'd7;
  localparam logic [3:0] OP_SLTS  = 4'd8;
  localparam logic [3:0] OP_SLTU  = 4'd9;
  localparam logic [3:0] OP_IN1   = 4'd10;
  localparam logic [3:0] OP_IN0P4 = 4'd11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             illegal_q, illegal_d;
  logic [SHW-1:0]   rem_q, rem_d;
  logic [3:0]       op_q, op_d;

  logic [SHW-1:0]   shamt;
  logic             is_shift;
  logic             accept;
  logic [SHW-1:0]   step;

  assign shamt    = in1[SHW-1:0];
  assign is_shift = (aluselect == OP_SLL) || (aluselect == OP_SRL) || (aluselect == OP_SRA);
  assign accept   = in_valid && (state_q == S_IDLE);
  assign step     = (rem_q > SHW'(SHIFT_STEP)) ? SHW'(SHIFT_STEP) : rem_q;

  // State and datapath registers; reset discards any op in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      result_q  <= '0;
      illegal_q <= 1'b0;
      rem_q     <= '0;
      op_q      <= 4'd0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
      rem_q     <= rem_d;
      op_q      <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = (is_shift && (shamt != '0)) ? S_SHIFT : S_DONE;
      S_SHIFT: if (rem_q <= SHW'(SHIFT_STEP)) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake decode and datapath next-state; shifts start from in0 and walk one step per cycle.
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    result_d  = result_q;
    illegal_d = illegal_q;
    rem_d     = rem_q;
    op_d      = op_q;
    if (accept) begin
      illegal_d = 1'b0;
      op_d      = aluselect;
      rem_d     = shamt;
      case (aluselect)
        OP_ADD:                 result_d = in0 + in1;
        OP_SUB:                 result_d = in0 - in1;
        OP_SLL, OP_SRL, OP_SRA: result_d = in0;
        OP_AND:                 result_d = in0 & in1;
        OP_OR:                  result_d = in0 | in1;
        OP_XOR:                 result_d = in0 ^ in1;
        OP_SLTS:                result_d = WIDTH'($signed(in0) < $signed(in1));
        OP_SLTU:                result_d = WIDTH'(in0 < in1);
        OP_IN1:                 result_d = in1;
        OP_IN0P4:               result_d = in0 + WIDTH'(4);
        default: begin
          result_d  = '0;
          illegal_d = 1'b1;
        end
      endcase
    end else if (state_q == S_SHIFT) begin
      rem_d = rem_q - step;
      case (op_q)
        OP_SLL:  result_d = result_q << step;
        OP_SRL:  result_d = result_q >> step;
        default: result_d = $unsigned($signed(result_q) >>> step);
      endcase
    end
  end

  assign result  = result_q;
  assign illegal = illegal_q;

endmodule
